reset_sequencer: RTL

- Sits directly downstream of the per-domain reset synchroniser.
- Takes the synchronised active-low reset plus a PLL/clock lock indication.
- Releases NUM_OUT active-low reset outputs one after another, in a fixed order with programmable spacing, so that interconnect, caches and core come out of reset in a defined sequence.
- Also supports a software-requested warm reset and re-asserts all outputs on loss of lock.

---
 rtl/reset_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Sequenced active-low reset release gated by a filtered PLL lock, with warm-reset hold.
// Optional lock-timeout fallback is enabled by defining RST_SEQ_LOCK_TIMEOUT_EN.
module reset_sequencer #(
    parameter int unsigned NUM_OUT         = 3,
    parameter int unsigned STAGE_DELAY     = 16,
    parameter int unsigned LOCK_FILTER     = 4,
    parameter int unsigned SOFT_RST_CYCLES = 8
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
    ,
    parameter int unsigned LOCK_TIMEOUT    = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               lock_i,
    input  logic               soft_rst_i,
    output logic [NUM_OUT-1:0] rst_n_o,
    output logic               done_o,
    output logic               timeout_o
);

    localparam int unsigned SW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int unsigned LW = $clog2(LOCK_FILTER + 1);
    localparam int unsigned DW = $clog2(STAGE_DELAY + 1);
    localparam int unsigned HW = $clog2(SOFT_RST_CYCLES + 1);

    localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_OUT - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_FILTER - 1);
    localparam logic [DW-1:0] DLY_LAST   = DW'(STAGE_DELAY - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(SOFT_RST_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, RELEASE, RUN, SOFT_HOLD} state_e;

    state_e             state_q, state_d;
    logic [LW-1:0]      lock_cnt_q, lock_cnt_d;
    logic [DW-1:0]      dly_q, dly_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
    logic               done_q, done_d;
    logic               lock_ok;

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_q, timeout_d;

    // Once timed out the lock input is no longer trusted.
    assign lock_ok   = lock_i | timeout_q;
    assign timeout_o = timeout_q;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign lock_ok   = lock_i;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            dly_q      <= '0;
            stage_q    <= '0;
            hold_q     <= '0;
            rst_n_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            dly_q      <= dly_d;
            stage_q    <= stage_d;
            hold_q     <= hold_d;
            rst_n_q    <= rst_n_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        dly_d      = dly_q;
        stage_d    = stage_q;
        hold_d     = hold_q;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        timeout_d  = timeout_q;
`endif
        unique case (state_q)
            WAIT_LOCK: begin
                dly_d   = '0;
                stage_d = '0;
                hold_d  = '0;
                if (lock_i) begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_d    = RELEASE;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end else begin
                    lock_cnt_d = '0;
                end
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
                // Timeout count accumulates across WAIT_LOCK visits; the filter wins a tie.
                if (timeout_q) begin
                    state_d    = RELEASE;
                    lock_cnt_d = '0;
                end else if (state_d == WAIT_LOCK) begin
                    if (to_cnt_q == TO_LAST) begin
                        timeout_d  = 1'b1;
                        state_d    = RELEASE;
                        lock_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
`endif
            end
            RELEASE, RUN: begin
                if (!lock_ok) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                    dly_d      = '0;
                    stage_d    = '0;
                end else if (soft_rst_i) begin
                    state_d = SOFT_HOLD;
                    hold_d  = '0;
                    dly_d   = '0;
                    stage_d = '0;
                end else if (state_q == RELEASE) begin
                    if (dly_q == DLY_LAST) begin
                        dly_d = '0;
                        if (stage_q == STAGE_LAST) begin
                            state_d = RUN;
                            stage_d = '0;
                        end else begin
                            stage_d = stage_q + 1'b1;
                        end
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
            end
            SOFT_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                    hold_d     = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the transition.
    always_comb begin
        rst_n_d = '0;
        done_d  = 1'b0;
        if (state_d == RUN) begin
            rst_n_d = '1;
            done_d  = 1'b1;
        end else if (state_d == RELEASE) begin
            for (int unsigned k = 0; k < NUM_OUT; k++) begin
                rst_n_d[k] = (k < 32'(stage_d));
            end
        end
    end

    assign rst_n_o = rst_n_q;
    assign done_o  = done_q;

endmodule
